// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// SPI slave: oversamples the SPI pads in the system clock domain, shifts
// characters in from MOSI and out on MISO with configurable sample/drive
// edges and bit order, and talks to local logic through a one-entry TX
// holding buffer (valid/ready) and a one-cycle RX valid pulse.
module spi_slave #(
  parameter int CHAR_LEN    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                sclk_pad_i,
  input  logic                ss_pad_i,
  input  logic                mosi_pad_i,
  output logic                miso_pad_o,
  output logic                miso_oe_o,
  input  logic                lsb_i,
  input  logic                sample_negedge_i,
  input  logic                drive_negedge_i,
  input  logic [CHAR_LEN-1:0] tx_data_i,
  input  logic                tx_valid_i,
  output logic                tx_ready_o,
  output logic [CHAR_LEN-1:0] rx_data_o,
  output logic                rx_valid_o,
  output logic                tx_urun_o,
  output logic                abort_o,
  output logic                busy_o
);

  localparam int               CNT_W    = $clog2(CHAR_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LEN - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAR_LEN);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t state, state_next;

  // Pad synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_h, ss_h;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall;

  // Per-character configuration, frozen at character start
  logic lsb_q, samp_neg_q, drv_neg_q;
  logic sample_edge, drive_edge;

  // Datapath
  logic [CHAR_LEN-1:0] tx_buf, tx_shift, rx_shift, rx_next, load_word;
  logic                buf_full;
  logic [CNT_W-1:0]    bit_cnt;

  // FSM strobes
  logic do_load, do_sample, do_drive, do_done, do_abort, go_idle;

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign ss_s       = ss_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_h;
  assign sclk_fall  = ~sclk_s & sclk_h;
  assign ss_fall    = ~ss_s & ss_h;

  assign sample_edge = samp_neg_q ? sclk_fall : sclk_rise;
  assign drive_edge  = drv_neg_q  ? sclk_fall : sclk_rise;

  assign tx_ready_o  = ~buf_full;
  assign load_word   = buf_full ? tx_buf : '1;

  // Synchronise pads into wb_clk_i and keep one cycle of history for edges
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_h    <= 1'b0;
      ss_h      <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the chain.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pad_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_pad_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pad_i};
      sclk_h    <= sclk_s;
      ss_h      <= ss_s;
    end
  end

  // Receive shift register value after inserting the current MOSI sample
  always_comb begin
    rx_next = lsb_q ? {mosi_s, rx_shift[CHAR_LEN-1:1]}
                    : {rx_shift[CHAR_LEN-2:0], mosi_s};
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic and datapath strobes
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_drive   = 1'b0;
    do_done    = 1'b0;
    do_abort   = 1'b0;
    go_idle    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) state_next = LOAD;
      end
      LOAD: begin
        do_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        do_sample = sample_edge;
        do_drive  = drive_edge && (bit_cnt != '0) && (bit_cnt < FULL_CNT);
        // The sample is taken before ss is looked at, so a final bit that
        // coincides with ss rising still completes the character.
        if (sample_edge && (bit_cnt == LAST_BIT)) begin
          do_done    = 1'b1;
          go_idle    = ss_s;
          state_next = ss_s ? IDLE : LOAD;
        end else if (ss_s) begin
          go_idle    = 1'b1;
          do_abort   = (bit_cnt != '0) || sample_edge;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // TX holding buffer: local side fills it, character start empties it
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      // NOTE: data registers are reset too; the block is small and a known
      // value keeps MISO deterministic after a mid-character reset.
      tx_buf   <= '0;
      buf_full <= 1'b0;
    end else if (tx_valid_i && !buf_full) begin
      tx_buf   <= tx_data_i;
      buf_full <= 1'b1;
    end else if (do_load) begin
      buf_full <= 1'b0;
    end
  end

  // Shift datapath, MISO drive and status pulses
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      lsb_q      <= 1'b0;
      samp_neg_q <= 1'b0;
      drv_neg_q  <= 1'b0;
      miso_pad_o <= 1'b1;
      miso_oe_o  <= 1'b0;
      busy_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      tx_urun_o  <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      tx_urun_o  <= 1'b0;
      abort_o    <= 1'b0;

      if (do_load) begin
        tx_shift   <= load_word;
        tx_urun_o  <= ~buf_full;
        miso_pad_o <= lsb_i ? load_word[0] : load_word[CHAR_LEN-1];
        miso_oe_o  <= 1'b1;
        busy_o     <= 1'b1;
        bit_cnt    <= '0;
        lsb_q      <= lsb_i;
        samp_neg_q <= sample_negedge_i;
        drv_neg_q  <= drive_negedge_i;
      end

      if (do_sample) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + 1'b1;
      end

      if (do_drive) begin
        if (lsb_q) begin
          tx_shift   <= tx_shift >> 1;
          miso_pad_o <= tx_shift[1];
        end else begin
          tx_shift   <= tx_shift << 1;
          miso_pad_o <= tx_shift[CHAR_LEN-2];
        end
      end

      if (do_done) begin
        rx_data_o  <= rx_next;
        rx_valid_o <= 1'b1;
      end

      if (do_abort) abort_o <= 1'b1;

      if (go_idle) begin
        miso_oe_o  <= 1'b0;
        miso_pad_o <= 1'b1;
        busy_o     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Directed bench for spi_slave: a behavioural SPI master drives the pads,
// expected RX characters are queued as stimulus is issued and compared
// against what the DUT reports on rx_valid_o.
module tb_spi_slave;

  localparam int CL   = 8;
  localparam int HALF = 80;  // half sclk period, 8 system clocks

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic          lsb = 1'b0, samp_neg = 1'b0, drv_neg = 1'b1;
  logic [CL-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          miso, miso_oe, tx_ready, rx_valid, tx_urun, abort_p, busy;
  logic [CL-1:0] rx_data;

  always #5 clk = ~clk;

  spi_slave #(.CHAR_LEN(CL), .SYNC_STAGES(2)) dut (
    .wb_clk_i         (clk),
    .wb_rst_ni        (rst_n),
    .sclk_pad_i       (sclk),
    .ss_pad_i         (ss),
    .mosi_pad_i       (mosi),
    .miso_pad_o       (miso),
    .miso_oe_o        (miso_oe),
    .lsb_i            (lsb),
    .sample_negedge_i (samp_neg),
    .drive_negedge_i  (drv_neg),
    .tx_data_i        (tx_data),
    .tx_valid_i       (tx_valid),
    .tx_ready_o       (tx_ready),
    .rx_data_o        (rx_data),
    .rx_valid_o       (rx_valid),
    .tx_urun_o        (tx_urun),
    .abort_o          (abort_p),
    .busy_o           (busy)
  );

  int            total = 0;
  int            bad   = 0;
  logic [CL-1:0] exp_q[$];
  logic [CL-1:0] obs_q[$];
  int            rd_idx = 0;
  int            urun_cnt = 0;
  int            abort_cnt = 0;

  // Monitor: record every DUT output event away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) obs_q.push_back(rx_data);
      if (tx_urun)  urun_cnt++;
      if (abort_p)  abort_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input logic l, input logic cpha);
    lsb      = l;
    samp_neg = cpha;
    drv_neg  = ~cpha;
  endtask

  task automatic push_tx(input logic [CL-1:0] d);
    bit done = 1'b0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      if (tx_ready) done = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $error("FAIL tx_accept: observed=no_ready expected=ready");
    end
  endtask

  task automatic ss_low();
    @(negedge clk);
    ss = 1'b0;
  endtask

  // Behavioural master; mode taken from lsb/samp_neg set for the slave
  task automatic xfer(input logic [CL-1:0] m_word, input int nbits,
                      input bit end_ss, output logic [CL-1:0] s_word);
    int idx;
    s_word = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb ? i : CL - 1 - i;
      if (!samp_neg) begin
        mosi = m_word[idx];
        #(HALF);
        sclk = 1'b1;
        s_word[idx] = miso;
        if (end_ss && i == nbits - 1) ss = 1'b1;
        #(HALF);
        sclk = 1'b0;
      end else begin
        #(HALF);
        sclk = 1'b1;
        mosi = m_word[idx];
        #(HALF);
        sclk = 1'b0;
        s_word[idx] = miso;
        if (end_ss && i == nbits - 1) ss = 1'b1;
      end
    end
  endtask

  // Compare every queued expectation against what the monitor captured
  task automatic drain_rx();
    logic [CL-1:0] e;
    while (exp_q.size() > 0) begin
      for (int k = 0; k < 40 && obs_q.size() <= rd_idx; k++) @(negedge clk);
      e = exp_q.pop_front();
      if (obs_q.size() <= rd_idx) begin
        total++;
        bad++;
        $error("FAIL rx_missing: observed=none expected=%0h", e);
      end else begin
        check("rx_data", 32'(obs_q[rd_idx]), 32'(e));
        rd_idx++;
      end
    end
    repeat (4) @(negedge clk);
    check("rx_pulse_count", 32'(obs_q.size()), 32'(rd_idx));
  endtask

  initial begin
    logic [CL-1:0] s_word, s_word2;
    int            urun0, abort0;
    bit            seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_miso",     32'(miso),     32'h1);
    check("rst_miso_oe",  32'(miso_oe),  32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_data",  32'(rx_data),  32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_tx_urun",  32'(tx_urun),  32'h0);
    check("rst_abort",    32'(abort_p),  32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: MSB first, sample rising / drive falling, 0xA5 out, 0x3C in
    set_mode(1'b0, 1'b0);
    urun0 = urun_cnt;
    push_tx(8'hA5);
    check("t1_ready_low", 32'(tx_ready), 32'h0);
    exp_q.push_back(8'h3C);
    ss_low();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = busy;
    end
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_ready_after_load", 32'(tx_ready), 32'h1);
    check("t1_miso_oe", 32'(miso_oe), 32'h1);
    xfer(8'h3C, CL, 1'b1, s_word);
    check("t1_miso_word", 32'(s_word), 32'hA5);
    drain_rx();
    check("t1_rx_data_hold", 32'(rx_data), 32'h3C);
    check("t1_idle_oe", 32'(miso_oe), 32'h0);
    check("t1_idle_miso", 32'(miso), 32'h1);
    check("t1_idle_busy", 32'(busy), 32'h0);
    check("t1_no_urun", 32'(urun_cnt), 32'(urun0));

    // 2: LSB first, 0x01 out, 0x80 in
    set_mode(1'b1, 1'b0);
    push_tx(8'h01);
    exp_q.push_back(8'h80);
    ss_low();
    xfer(8'h80, CL, 1'b1, s_word);
    check("t2_miso_word", 32'(s_word), 32'h01);
    drain_rx();

    // 3: back-to-back characters, buffer refilled during the first
    set_mode(1'b0, 1'b0);
    urun0 = urun_cnt;
    push_tx(8'h11);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    ss_low();
    fork
      xfer(8'hC3, CL, 1'b0, s_word);
      push_tx(8'h55);
    join
    xfer(8'h5A, CL, 1'b1, s_word2);
    check("t3_miso_word1", 32'(s_word), 32'h11);
    check("t3_miso_word2", 32'(s_word2), 32'h55);
    drain_rx();
    check("t3_no_urun", 32'(urun_cnt), 32'(urun0));

    // 4: empty buffer underrun
    urun0 = urun_cnt;
    exp_q.push_back(8'h69);
    ss_low();
    xfer(8'h69, CL, 1'b1, s_word);
    check("t4_miso_ones", 32'(s_word), 32'hFF);
    drain_rx();
    check("t4_urun_pulse", 32'(urun_cnt), 32'(urun0 + 1));

    // 5: ss raised after five bits
    abort0 = abort_cnt;
    push_tx(8'h77);
    ss_low();
    xfer(8'hF0, 5, 1'b0, s_word);
    #(HALF);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_abort_pulse", 32'(abort_cnt), 32'(abort0 + 1));
    check("t5_no_rx", 32'(obs_q.size()), 32'(rd_idx));
    check("t5_rx_data_kept", 32'(rx_data), 32'h69);
    check("t5_oe_off", 32'(miso_oe), 32'h0);
    check("t5_busy_off", 32'(busy), 32'h0);

    // 6: reset mid-character, then a full transfer in the other edge mode
    set_mode(1'b0, 1'b1);
    push_tx(8'hE7);
    ss_low();
    xfer(8'hFF, 3, 1'b0, s_word);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_miso",    32'(miso),     32'h1);
    check("t6_rst_oe",      32'(miso_oe),  32'h0);
    check("t6_rst_busy",    32'(busy),     32'h0);
    check("t6_rst_rx_data", 32'(rx_data),  32'h0);
    check("t6_rst_ready",   32'(tx_ready), 32'h1);
    ss   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    push_tx(8'h3A);
    exp_q.push_back(8'h96);
    ss_low();
    xfer(8'h96, CL, 1'b1, s_word);
    check("t6_miso_word", 32'(s_word), 32'h3A);
    drain_rx();
    check("t6_rx_data_hold", 32'(rx_data), 32'h96);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
